// File: rtl/if_prefetch_unit_if.sv
// Bundle of the fetch stage's two handshakes.
//   Memory side : mem_req/mem_addr out, mem_gnt/mem_rvalid/mem_rdata in.
//   Decode side : inst_valid/inst_data/inst_pc out, inst_ready in.
// The master modport is the prefetch unit's view. The slave modport is the
// view of the memory and decode blocks that surround it.
interface if_prefetch_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output mem_req, mem_addr, inst_valid, inst_data, inst_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, inst_ready
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst_data, inst_pc,
        output mem_gnt, mem_rvalid, mem_rdata, inst_ready
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
// The stage owns the fetch PC and keeps at most one memory request in flight.
// It buffers {pc, instruction} pairs and presents the oldest pair to decode.
// A taken branch flushes the queue and discards any response still in flight.
// Ports:
//   CLK, RST_N  clock (rising edge) and asynchronous active-low reset
//   pc_WPC      fetch enable (gates new requests only)
//   tf_out      branch-taken pulse; alu_result is the redirect target
//   bus         memory and decode handshakes (master modport)
//   mxpc_out    current fetch PC, i.e. the next address to request
//   q_count     number of queued entries
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | nothing in flight; raise a request when enabled and space is free
// REQ    | request raised, waiting for mem_gnt; mem_addr held stable
// WAIT   | request granted, response will be pushed into the queue
// DROP   | request granted but a redirect happened since; discard response
module if_prefetch_unit #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_INC   = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         pc_WPC,
    input  logic                         tf_out,
    input  logic [ADDR_W-1:0]            alu_result,
    if_prefetch_unit_if.master           bus,
    output logic [ADDR_W-1:0]            mxpc_out,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tag;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];

    logic req, push, pop, grant, space_ok;

    // Only IDLE can start a request, and nothing is in flight in IDLE.
    // So this check alone reserves the slot for the eventual response.
    assign space_ok = (count < CW'(DEPTH));
    assign grant    = req && bus.mem_gnt;
    assign pop      = (count != '0) && bus.inst_ready && !tf_out;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            tag   <= '0;
        end else begin
            state <= state_nxt;
            if (tf_out) begin
                pc <= alu_result;
            end else if (grant) begin
                pc <= pc + ADDR_W'(PC_INC);
            end
            if (grant) begin
                tag <= pc;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        push      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!tf_out && pc_WPC && space_ok) begin
                    req       = 1'b1;
                    state_nxt = bus.mem_gnt ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                // Dropping pc_WPC does not withdraw the request; a redirect does.
                if (tf_out) begin
                    state_nxt = S_IDLE;
                end else begin
                    req = 1'b1;
                    if (bus.mem_gnt) begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    // A response that lands in the same cycle as a redirect is stale.
                    push      = !tf_out;
                    state_nxt = S_IDLE;
                end else if (tf_out) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.mem_rvalid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (tf_out) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= bus.mem_rdata;
                q_pc[wr_ptr]   <= tag;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // mem_req is gated by reset so that it reads 0 as soon as RST_N falls.
    assign bus.mem_req    = req && RST_N;
    assign bus.mem_addr   = pc;
    assign bus.inst_valid = (count != '0);
    assign bus.inst_data  = q_data[rd_ptr];
    assign bus.inst_pc    = q_pc[rd_ptr];
    assign mxpc_out       = pc;
    assign q_count        = count;
endmodule
